// File: rtl/sw_matrix_ctrl.sv
// Smith-Waterman matrix sequencer: owns the symbol and row buffers, walks the
// cells in row-major order through one shared registered PE, and tracks the best cell.
`timescale 1ns/1ps
module sw_matrix_ctrl #(
  parameter int SEQ1_MAX = 32,
  parameter int SEQ2_MAX = 32,
  parameter int SCORE_W  = 32,
  parameter int LEN_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   len1,
  input  logic [LEN_W-1:0]   len2,
  input  logic               load_valid,
  input  logic               load_sel,
  input  logic [LEN_W-1:0]   load_addr,
  input  logic [2:0]         load_data,
  output logic [2:0]         pe_seq1,
  output logic [2:0]         pe_seq2,
  output logic [SCORE_W-1:0] pe_diag,
  output logic [SCORE_W-1:0] pe_left,
  output logic [SCORE_W-1:0] pe_top,
  input  logic [SCORE_W-1:0] pe_score,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SCORE_W-1:0] max_score,
  output logic [LEN_W-1:0]   max_i,
  output logic [LEN_W-1:0]   max_j
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEPTH = 1 << LEN_W;
  localparam logic [LEN_W-1:0] IDX_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] IDX_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t state_r, state_s;

  logic [2:0]         seq1_mem [DEPTH];
  logic [2:0]         seq2_mem [DEPTH];
  logic [SCORE_W-1:0] row_mem  [DEPTH];

  logic [LEN_W-1:0] len1_r, len2_r, i_r, j_r;
  logic [LEN_W-1:0] i_inc_s, j_inc_s;
  logic             len_ok_s, accept_s, reject_s, last_col_s, last_row_s;

  assign len_ok_s   = (len1 != IDX_ZERO) && (len1 <= LEN_W'(SEQ1_MAX)) &&
                      (len2 != IDX_ZERO) && (len2 <= LEN_W'(SEQ2_MAX));
  assign accept_s   = (state_r == S_IDLE) && start && len_ok_s;
  assign reject_s   = (state_r == S_IDLE) && start && !len_ok_s;
  assign last_col_s = (j_r == len2_r);
  assign last_row_s = (i_r == len1_r);
  assign i_inc_s    = i_r + IDX_ONE;
  assign j_inc_s    = j_r + IDX_ONE;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) state_s = S_INIT; else state_s = S_IDLE;
      S_INIT:  if (last_col_s) state_s = S_ISSUE; else state_s = S_INIT;
      S_ISSUE: state_s = S_WAIT;
      S_WAIT:  if (last_col_s && last_row_s) state_s = S_DONE; else state_s = S_ISSUE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Symbol buffers (host loads in IDLE) and row buffer (clear in INIT, write-back in WAIT)
  always_ff @(posedge clk) begin
    if (state_r == S_IDLE && load_valid) begin
      if (!load_sel && load_addr < LEN_W'(SEQ1_MAX)) seq1_mem[load_addr] <= load_data;
      if (load_sel && load_addr < LEN_W'(SEQ2_MAX))  seq2_mem[load_addr] <= load_data;
    end
    if (state_r == S_INIT)      row_mem[j_r] <= {SCORE_W{1'b0}};
    else if (state_r == S_WAIT) row_mem[j_r] <= pe_score;
  end

  // Cell indices, PE operands for the next ISSUE, best-cell tracking and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len1_r    <= IDX_ZERO;
      len2_r    <= IDX_ZERO;
      i_r       <= IDX_ZERO;
      j_r       <= IDX_ZERO;
      pe_seq1   <= 3'd0;
      pe_seq2   <= 3'd0;
      pe_diag   <= {SCORE_W{1'b0}};
      pe_left   <= {SCORE_W{1'b0}};
      pe_top    <= {SCORE_W{1'b0}};
      max_score <= {SCORE_W{1'b0}};
      max_i     <= IDX_ZERO;
      max_j     <= IDX_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy <= (state_s != S_IDLE);
      done <= (state_s == S_DONE);
      err  <= reject_s;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            len1_r    <= len1;
            len2_r    <= len2;
            j_r       <= IDX_ZERO;
            max_score <= {SCORE_W{1'b0}};
            max_i     <= IDX_ZERO;
            max_j     <= IDX_ZERO;
          end
        end
        S_INIT: begin
          if (!last_col_s) begin
            j_r <= j_inc_s;
          end else begin
            i_r     <= IDX_ONE;
            j_r     <= IDX_ONE;
            pe_seq1 <= seq1_mem[IDX_ZERO];
            pe_seq2 <= seq2_mem[IDX_ZERO];
            pe_diag <= {SCORE_W{1'b0}};
            pe_left <= {SCORE_W{1'b0}};
            pe_top  <= {SCORE_W{1'b0}};
          end
        end
        S_WAIT: begin
          if (pe_score > max_score) begin
            max_score <= pe_score;
            max_i     <= i_r;
            max_j     <= j_r;
          end
          if (!last_col_s) begin
            j_r     <= j_inc_s;
            pe_seq2 <= seq2_mem[j_r];
            pe_diag <= row_mem[j_r];
            pe_left <= pe_score;
            pe_top  <= row_mem[j_inc_s];
          end else if (!last_row_s) begin
            i_r     <= i_inc_s;
            j_r     <= IDX_ONE;
            pe_seq1 <= seq1_mem[i_r];
            pe_seq2 <= seq2_mem[IDX_ZERO];
            pe_diag <= {SCORE_W{1'b0}};
            pe_left <= {SCORE_W{1'b0}};
            // A single-column matrix reads back the cell being written this cycle.
            pe_top  <= (len2_r == IDX_ONE) ? pe_score : row_mem[IDX_ONE];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_matrix_ctrl.sv
// Directed bench for sw_matrix_ctrl with a behavioural PE
// (match +2, mismatch -1, linear gap 1, clamp at 0).
`timescale 1ns/1ps
module tb_sw_matrix_ctrl;
  localparam int LEN_W = 6;
  localparam int SCORE_W = 32;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [LEN_W-1:0] len1 = '0, len2 = '0, load_addr = '0;
  logic load_valid = 1'b0, load_sel = 1'b0;
  logic [2:0] load_data = 3'd0, pe_seq1, pe_seq2;
  logic [SCORE_W-1:0] pe_diag, pe_left, pe_top, pe_score, max_score;
  logic busy, done, err;
  logic [LEN_W-1:0] max_i, max_j;

  int n_chk = 0, n_fail = 0;

  sw_matrix_ctrl #(.SEQ1_MAX(32), .SEQ2_MAX(32), .SCORE_W(SCORE_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len1(len1), .len2(len2),
    .load_valid(load_valid), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .pe_seq1(pe_seq1), .pe_seq2(pe_seq2), .pe_diag(pe_diag), .pe_left(pe_left), .pe_top(pe_top),
    .pe_score(pe_score), .busy(busy), .done(done), .err(err),
    .max_score(max_score), .max_i(max_i), .max_j(max_j)
  );

  always #5 clk = ~clk;

  // Behavioural registered PE
  always @(posedge clk) begin
    int d, l, t, h;
    d = int'(pe_diag) + ((pe_seq1 == pe_seq2) ? 2 : -1);
    l = int'(pe_left) - 1;
    t = int'(pe_top) - 1;
    h = 0;
    if (d > h) h = d;
    if (l > h) h = l;
    if (t > h) h = t;
    pe_score <= SCORE_W'(h);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] code(input byte ch);
    case (ch)
      "A":     return 3'd0;
      "C":     return 3'd1;
      "G":     return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

  task automatic load_seq(input logic sel, input string s);
    for (int k = 0; k < s.len(); k++) begin
      @(posedge clk); #1;
      load_valid = 1'b1; load_sel = sel; load_addr = LEN_W'(k); load_data = code(s[k]);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Start in cycle 0; return the cycle of done, busy-low cycles and err pulses seen.
  // inj > 0 pulses start and a seq1[0]=T load in that cycle of the run.
  task automatic run(input int l1, input int l2, input int inj,
                     output int dcyc, output int gaps, output int errs);
    dcyc = -1; gaps = 0; errs = 0;
    @(posedge clk); #1;
    len1 = LEN_W'(l1); len2 = LEN_W'(l2); start = 1'b1;
    @(negedge clk);
    chk("idle_busy_low", busy, 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 5000; c++) begin
      if (inj > 0 && c == inj) begin
        start = 1'b1; len1 = LEN_W'(1); len2 = LEN_W'(1);
        load_valid = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = 3'd3;
      end else begin
        start = 1'b0; load_valid = 1'b0;
      end
      @(negedge clk);
      if (!busy) gaps++;
      if (err) errs++;
      if (done) begin
        dcyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; load_valid = 1'b0;
  endtask

  typedef struct {
    string s1;
    string s2;
    int l1, l2, cyc, mx, mi, mj;
    bit reload;
  } vec_t;

  vec_t vecs [6];
  int dcyc, gaps, errs;

  initial begin
    vecs[0] = '{"ACGT", "ACGT", 4, 4, 38, 8, 4, 4, 1'b1};
    vecs[1] = '{"AAAA", "CCCC", 4, 4, 38, 0, 0, 0, 1'b1};
    vecs[2] = '{"A", "AA", 1, 2, 8, 2, 1, 1, 1'b1};
    vecs[3] = '{"GAT", "AT", 3, 2, 16, 4, 3, 2, 1'b1};
    vecs[4] = '{"ACGTACGTACGTACGTACGTACGTACGTACGT", "ACGTACGTACGTACGTACGTACGTACGTACGT",
                32, 32, 2082, 64, 32, 32, 1'b1};
    vecs[5] = '{"", "", 32, 32, 2082, 64, 32, 32, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_max", max_score, 0);
    chk("rst_max_ij", {max_i, max_j}, 0);
    chk("rst_pe_ops", pe_diag | pe_left | pe_top, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].reload) begin
        load_seq(1'b0, vecs[v].s1);
        load_seq(1'b1, vecs[v].s2);
      end
      run(vecs[v].l1, vecs[v].l2, 0, dcyc, gaps, errs);
      chk($sformatf("v%0d_done_cycle", v), dcyc, vecs[v].cyc);
      chk($sformatf("v%0d_busy_gaps", v), gaps, 0);
      chk($sformatf("v%0d_err", v), errs, 0);
      chk($sformatf("v%0d_max_score", v), max_score, vecs[v].mx);
      chk($sformatf("v%0d_max_i", v), max_i, vecs[v].mi);
      chk($sformatf("v%0d_max_j", v), max_j, vecs[v].mj);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", v), done, 0);
    end

    // Rejected starts: zero length and over-long length
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      start = 1'b1;
      len1 = (e == 0) ? LEN_W'(4) : LEN_W'(33);
      len2 = (e == 0) ? LEN_W'(0) : LEN_W'(4);
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("rej%0d_err_pulse", e), err, 1);
      chk($sformatf("rej%0d_busy", e), busy, 0);
      @(posedge clk); #1;
      chk($sformatf("rej%0d_err_clear", e), err, 0);
      chk($sformatf("rej%0d_busy2", e), busy, 0);
      chk($sformatf("rej%0d_max_kept", e), max_score, 64);
      chk($sformatf("rej%0d_max_ij_kept", e), {max_i, max_j}, {6'd32, 6'd32});
    end

    // Start and load while busy are ignored (load lands during INIT)
    load_seq(1'b0, "ACGT");
    load_seq(1'b1, "ACGT");
    run(4, 4, 3, dcyc, gaps, errs);
    chk("busy_ign_done_cycle", dcyc, 38);
    chk("busy_ign_err", errs, 0);
    chk("busy_ign_gaps", gaps, 0);
    chk("busy_ign_max", max_score, 8);
    chk("busy_ign_max_ij", {max_i, max_j}, {6'd4, 6'd4});

    // Reset in cycle 20 of an ACGT run, then rerun without reloading
    @(posedge clk); #1;
    len1 = LEN_W'(4); len2 = LEN_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done_err", {done, err}, 0);
    chk("mid_rst_max", max_score, 0);
    chk("mid_rst_max_ij", {max_i, max_j}, 0);
    chk("mid_rst_pe_ops", pe_diag | pe_left | pe_top, 0);
    chk("mid_rst_pe_syms", {pe_seq1, pe_seq2}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run(4, 4, 0, dcyc, gaps, errs);
    chk("rerun_done_cycle", dcyc, 38);
    chk("rerun_max", max_score, 8);
    chk("rerun_max_ij", {max_i, max_j}, {6'd4, 6'd4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_matrix_ctrl.md
Name: sw_matrix_ctrl

Overview:
Sequencer that computes a full Smith-Waterman score matrix using one shared, registered SW processing element (PE) with a 1-cycle latency.
- Holds the query (seq1) and reference (seq2) symbol buffers.
- Walks the cells in row-major order, feeding each cell its diag/left/top operands from a single row buffer.
- Tracks the maximum cell score and its position, and reports completion.
- Sits between the host/load logic and the PE instance.

Parameters:
SEQ1_MAX, 32, max query length (rows)
SEQ2_MAX, 32, max reference length (columns)
SCORE_W, 32, score width (must match PE)
LEN_W, 6, length/index width, >= clog2(max(SEQ1_MAX,SEQ2_MAX)+1)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
start  in  1  request a run; sampled only in IDLE
len1  in  LEN_W  query length, valid range 1..SEQ1_MAX
len2  in  LEN_W  reference length, valid range 1..SEQ2_MAX
load_valid  in  1  write one symbol into a sequence buffer
load_sel  in  1  buffer select: 0 = seq1 buffer, 1 = seq2 buffer
load_addr  in  LEN_W  symbol index, 0-based
load_data  in  3  symbol code
pe_seq1  out  3  query symbol for the current cell
pe_seq2  out  3  reference symbol for the current cell
pe_diag  out  SCORE_W  H(i-1,j-1)
pe_left  out  SCORE_W  H(i,j-1)
pe_top  out  SCORE_W  H(i-1,j)
pe_score  in  SCORE_W  PE registered result; valid the cycle after ISSUE
busy  out  1  high from INIT through DONE inclusive
done  out  1  one-cycle pulse in DONE
err  out  1  one-cycle pulse when start is rejected
max_score  out  SCORE_W  best cell score of the last run
max_i  out  LEN_W  1-based row of max_score (0 if none)
max_j  out  LEN_W  1-based column of max_score (0 if none)

Behaviour:
- Reset (async):
  - state=IDLE; busy, done, err, max_score, max_i, max_j = 0.
  - PE operand outputs = 0.
  - Sequence buffers and row buffer are not reset; their contents are retained.
- Loads:
  - Accepted only in IDLE; ignored while busy.
  - An out-of-range load_addr is ignored.
- States:
  - IDLE -> INIT on start with len1 and len2 both in range.
    - The accepting edge latches len1/len2 and clears max_score/max_i/max_j.
  - Start with either length 0 or above its max: stay IDLE, pulse err next cycle.
  - Start while busy: ignored, no err.
  - INIT: clear row buffer entries 0..len2, one per cycle (len2+1 cycles); then i=1, j=1 -> ISSUE.
  - Row start: diag_reg=0, left_reg=0.
  - ISSUE: drive operands; PE samples at the end of the cycle.
    - pe_seq1 = seq1[i-1], pe_seq2 = seq2[j-1].
    - pe_diag = diag_reg, pe_left = left_reg, pe_top = row[j].
  - WAIT: pe_score is valid.
    - diag_reg <= row[j] (old value); row[j] <= pe_score; left_reg <= pe_score.
    - If pe_score > max_score (strictly): max_score <= pe_score, max_i <= i, max_j <= j. Ties keep the first cell in row-major order.
    - Transitions:
      - j < len2: j++, -> ISSUE.
      - j == len2 and i < len1: i++, j=1, diag_reg=0, left_reg=0, -> ISSUE.
      - Last cell: -> DONE.
  - DONE: done=1 for one cycle, -> IDLE. Results hold until the next accepted start.
- Timing: start sampled in cycle 0 gives INIT in cycles 1..len2+1, first ISSUE in cycle len2+2, 2 cycles per cell, done in cycle len2+2+2*len1*len2.
- Operand outputs are don't-care outside ISSUE but must not glitch X; they hold their last values.
- Scores are unsigned (the PE clamps at 0). No saturation is required; the maximum is 2*min(len1,len2) for a match score of 2.
- Reset mid-run aborts immediately; a subsequent run gives results identical to a clean run.

Test Plan:
- Encoding A=0, C=1, G=2, T=3. Load seq1=ACGT, seq2=ACGT; len1=len2=4, start@0 -> done@38, max_score=8, max_i=4, max_j=4, busy high cycles 1..38.
- seq1=AAAA, seq2=CCCC, len 4/4 -> done@38, max_score=0, max_i=0, max_j=0.
- Tie: seq1=A, seq2=AA, len1=1, len2=2 -> H(1,1)=2, H(1,2)=2; max_score=2 at (1,1); done@8.
- start with len2=0, then with len1=33 -> err pulse one cycle after each, busy stays 0, prior max outputs unchanged; start during busy ignored; loads during busy do not alter the buffers.
- Assert reset in cycle 20 of the ACGT run -> all outputs 0 next cycle; rerun without reloading -> done@38, max 8 at (4,4).
- 32x32 identical sequences -> done@2082, max_score=64 at (32,32); back-to-back start accepted in the cycle after done.
